// File: rtl/secmem_pkg.sv
// Shared types and default constants for the secure memory arbiter.
// The sequencer states and the secure-policy constants live here.
package secmem_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] OPEN_ADDR = 5'd31;
    localparam logic [DATA_W-1:0] DENY_CHAR = 8'h3F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first active request
// found searching upward (with wrap) from the slot after the last winner.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!any_req && req[idx]) begin
                any_req    = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/secure_memory_arbiter.sv
// Round-robin front end for a single synchronous memory read port that only
// ever exposes OPEN_ADDR, answers everything else with DENY_CHAR, and locks out
// after repeated denials. Every read takes the same three-cycle path.
module secure_memory_arbiter #(
    parameter int                              NUM_REQ        = 2,
    parameter int                              ADDR_W         = secmem_pkg::ADDR_W,
    parameter int                              DATA_W         = secmem_pkg::DATA_W,
    parameter logic [secmem_pkg::ADDR_W-1:0]   OPEN_ADDR      = secmem_pkg::OPEN_ADDR,
    parameter logic [secmem_pkg::DATA_W-1:0]   DENY_CHAR      = secmem_pkg::DENY_CHAR,
    parameter int                              MAX_DENIES     = 4,
    parameter int                              LOCKOUT_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [ADDR_W-1:0]           mem_address,
    input  logic [DATA_W-1:0]           mem_value,
    output logic                        locked
);

    import secmem_pkg::*;

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int DENY_W = $clog2(MAX_DENIES + 1);
    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [DENY_W-1:0] DENY_MAX  = DENY_W'(MAX_DENIES);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] OPEN_A    = ADDR_W'(OPEN_ADDR);
    localparam logic [DATA_W-1:0] DENY_C    = DATA_W'(DENY_CHAR);

    function automatic logic [DENY_W-1:0] deny_sat_inc(input logic [DENY_W-1:0] cnt);
        if (cnt >= DENY_MAX) begin
            return DENY_MAX;
        end
        return cnt + 1'b1;
    endfunction

    state_t               state_q,       state_d;
    logic [IDX_W-1:0]     grant_idx_q,   grant_idx_d;
    logic [IDX_W-1:0]     rr_last_q,     rr_last_d;
    logic [ADDR_W-1:0]    addr_q,        addr_d;
    logic                 allowed_q,     allowed_d;
    logic [ADDR_W-1:0]    mem_address_q, mem_address_d;
    logic [NUM_REQ-1:0]   rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q,    rsp_data_d;
    logic [DENY_W-1:0]    deny_cnt_q,    deny_cnt_d;
    logic [LOCK_W-1:0]    lock_cnt_q,    lock_cnt_d;
    logic                 locked_q,      locked_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic [ADDR_W-1:0]    win_addr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .last      (rr_last_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    assign win_addr  = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
    assign req_ready = (state_q == IDLE) ? arb_grant : '0;

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        rr_last_d     = rr_last_q;
        addr_d        = addr_q;
        allowed_d     = allowed_q;
        mem_address_d = mem_address_q;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        deny_cnt_d    = deny_cnt_q;
        lock_cnt_d    = lock_cnt_q;
        locked_d      = locked_q;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_idx_d = arb_idx;
                    rr_last_d   = arb_idx;
                    addr_d      = win_addr;
                    allowed_d   = (win_addr == OPEN_A);
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // A denied address must never appear on the memory bus.
                if (allowed_q) begin
                    mem_address_d = addr_q;
                end
                state_d = WAIT;
            end
            WAIT: begin
                rsp_data_d             = allowed_q ? mem_value : DENY_C;
                rsp_valid_d[grant_idx_q] = 1'b1;
                state_d                = IDLE;
                if (!allowed_q) begin
                    deny_cnt_d = deny_sat_inc(deny_cnt_q);
                    if (deny_cnt_d == DENY_MAX) begin
                        state_d  = LOCKOUT;
                        locked_d = 1'b1;
                    end
                end
            end
            LOCKOUT: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    lock_cnt_d = '0;
                    deny_cnt_d = '0;
                    locked_d   = 1'b0;
                    state_d    = IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_idx_q   <= '0;
            rr_last_q     <= IDX_W'(NUM_REQ - 1);
            addr_q        <= '0;
            allowed_q     <= 1'b0;
            mem_address_q <= OPEN_A;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            deny_cnt_q    <= '0;
            lock_cnt_q    <= '0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            rr_last_q     <= rr_last_d;
            addr_q        <= addr_d;
            allowed_q     <= allowed_d;
            mem_address_q <= mem_address_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            deny_cnt_q    <= deny_cnt_d;
            lock_cnt_q    <= lock_cnt_d;
            locked_q      <= locked_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign mem_address = mem_address_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_secure_memory_arbiter.sv
// Self-checking bench for secure_memory_arbiter: a timeline-based reference
// model (when the port is free, when responses land, when lockout ends).
module tb_secure_memory_arbiter;

    localparam int N    = 2;
    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int MAXD = 4;
    localparam int LOCK = 16;
    localparam int OW   = 2*N + DW + AW + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_value;
    logic            locked;

    logic [DW-1:0]   mem [32];
    logic [OW-1:0]   obs;
    logic [OW-1:0]   m_exp;
    logic [OW-1:0]   reset_vec;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state, expressed as cycle numbers on a timeline
    int          mc = 0;
    int          m_free = 0;
    int          m_pend = -1;
    int          m_pend_req = 0;
    logic [DW-1:0] m_pend_data = '0;
    logic [DW-1:0] m_data = '0;
    int          m_rr = N - 1;
    int          m_deny = 0;
    int          m_lock_s = 0;
    int          m_lock_e = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_value <= mem[mem_address];

    assign obs = {req_ready, rsp_valid, rsp_data, mem_address, locked};

    secure_memory_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .mem_address (mem_address),
        .mem_value   (mem_value),
        .locked      (locked)
    );

    task automatic step(input logic r, input logic [N-1:0] v, input logic [N*AW-1:0] a,
                        output logic hs);
        logic [N-1:0] rdy;
        logic [N-1:0] rv;
        logic         found;
        int           w;
        int           j;
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = r ? '0 : v;
        req_addr  = a;
        rdy = '0; rv = '0; hs = 1'b0; found = 1'b0; w = 0;
        if (r) begin
            m_free = mc + 1; m_pend = -1; m_rr = N - 1; m_deny = 0;
            m_lock_s = 0; m_lock_e = 0; m_data = '0;
        end else begin
            if (mc == m_pend) begin
                rv[m_pend_req] = 1'b1;
                m_data = m_pend_data;
                m_pend = -1;
            end
            if (mc >= m_free && v != '0) begin
                for (int k = 1; k <= N; k++) begin
                    j = (m_rr + k) % N;
                    if (!found && v[j]) begin
                        found = 1'b1;
                        w = j;
                    end
                end
                rdy[w] = 1'b1; hs = 1'b1; m_rr = w;
                m_pend = mc + 3; m_pend_req = w;
                if (a[w*AW +: AW] == 5'd31) begin
                    m_pend_data = mem[31];
                    m_free = mc + 3;
                end else begin
                    m_pend_data = 8'h3F;
                    m_deny = m_deny + 1;
                    if (m_deny >= MAXD) begin
                        m_deny = 0;
                        m_lock_s = mc + 3;
                        m_lock_e = mc + 3 + LOCK;
                        m_free = m_lock_e;
                    end else begin
                        m_free = mc + 3;
                    end
                end
            end
        end
        m_exp = {rdy, rv, m_data, 5'd31, (mc >= m_lock_s && mc < m_lock_e)};
        mc++;
        @(negedge clk);
    endtask

    // One read by requester rq; checks cycle-by-cycle, the T->T+3 latency and the data.
    task automatic one_read(input int rq, input logic [AW-1:0] ad, input logic [DW-1:0] want);
        logic [N-1:0]    v;
        logic [N*AW-1:0] a;
        logic            hs;
        int              lat;
        v = '0; v[rq] = 1'b1;
        a = N*AW'($urandom);
        a[rq*AW +: AW] = ad;
        hs = 1'b0;
        for (int i = 0; i < 40 && !hs; i++) begin
            step(1'b0, v, a, hs);
            n_cmp++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL read_req cyc %0d: got %h want %h", mc, obs, m_exp);
            end
        end
        n_cmp++;
        if (!hs) begin
            n_fail++;
            $display("FAIL read_handshake_timeout req %0d: got none want handshake", rq);
        end
        lat = -1;
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, '0, a, hs);
            n_cmp++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL read_rsp cyc %0d: got %h want %h", mc, obs, m_exp);
            end
            if (rsp_valid[rq] && lat < 0) lat = k;
        end
        n_cmp++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL latency req %0d addr %0d: got %0d want 3", rq, ad, lat);
        end
        n_cmp++;
        if (rsp_data !== want) begin
            n_fail++;
            $display("FAIL rsp_data req %0d addr %0d: got %h want %h", rq, ad, rsp_data, want);
        end
    endtask

    task automatic test_reset();
        logic hs;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, '0, '0, hs);
            n_cmp++;
            if (obs !== reset_vec) begin
                n_fail++;
                $display("FAIL reset_values: got %h want %h", obs, reset_vec);
            end
        end
    endtask

    task automatic test_allowed();
        mem[31] = 8'h7D;
        one_read(0, 5'd31, 8'h7D);
    endtask

    task automatic test_denied();
        one_read(1, 5'd5, 8'h3F);
    endtask

    task automatic test_alternate();
        logic hs;
        int   g;
        step(1'b1, '0, '0, hs);
        g = 0;
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 2'b11, {5'd31, 5'd31}, hs);
            n_cmp++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL alternate cyc %0d: got %h want %h", mc, obs, m_exp);
            end
            if (req_ready != '0) begin
                n_cmp++;
                if (req_ready !== ((g % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL grant_order #%0d: got %b want %0d", g, req_ready, g % 2);
                end
                g++;
            end
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, hs);
        n_cmp++;
        if (g != 5) begin
            n_fail++;
            $display("FAIL grant_count: got %0d want 5", g);
        end
    endtask

    task automatic test_lockout();
        logic hs;
        int   nlock;
        step(1'b1, '0, '0, hs);
        mem[31] = 8'hA5;
        for (int i = 0; i < MAXD; i++) one_read(0, 5'd0, 8'h3F);
        nlock = locked ? 1 : 0;
        for (int i = 0; i < 22; i++) begin
            step(1'b0, 2'b10, {5'd31, 5'd0}, hs);
            n_cmp++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL lockout cyc %0d: got %h want %h", mc, obs, m_exp);
            end
            if (locked) nlock++;
            if (hs) break;
        end
        n_cmp++;
        if (nlock !== LOCK) begin
            n_fail++;
            $display("FAIL lock_len: got %0d want %0d", nlock, LOCK);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, hs);
        n_cmp++;
        if (rsp_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL post_lock_read: got %h want a5", rsp_data);
        end
        for (int i = 0; i < MAXD - 1; i++) one_read(1, 5'd9, 8'h3F);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL deny_cleared: got locked=%b want 0", locked);
        end
    endtask

    task automatic test_reset_mid();
        logic hs;
        step(1'b1, '0, '0, hs);
        mem[31] = 8'h66;
        one_read(1, 5'd31, 8'h66);
        step(1'b0, 2'b01, {5'd0, 5'd31}, hs);
        step(1'b0, '0, '0, hs);
        step(1'b1, '0, '0, hs);
        n_cmp++;
        if (obs !== reset_vec) begin
            n_fail++;
            $display("FAIL mid_reset_values: got %h want %h", obs, reset_vec);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0, hs);
            n_cmp++;
            if (obs !== reset_vec) begin
                n_fail++;
                $display("FAIL mid_reset_no_rsp cyc %0d: got %h want %h", mc, obs, reset_vec);
            end
        end
        one_read(0, 5'd31, 8'h66);
    endtask

    task automatic test_mixed();
        logic hs;
        step(1'b1, '0, '0, hs);
        mem[31] = 8'h42;
        one_read(0, 5'd3, 8'h3F);
        one_read(1, 5'd30, 8'h3F);
        one_read(0, 5'd17, 8'h3F);
        one_read(1, 5'd31, 8'h42);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL mixed_early_lock: got %b want 0", locked);
        end
        one_read(0, 5'd1, 8'h3F);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL mixed_lock: got %b want 1", locked);
        end
        for (int i = 0; i < LOCK + 2; i++) begin
            step(1'b0, '0, '0, hs);
            n_cmp++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL mixed_tail cyc %0d: got %h want %h", mc, obs, m_exp);
            end
        end
    endtask

    task automatic test_random();
        logic            hs;
        logic [N-1:0]    v;
        logic [N*AW-1:0] a;
        step(1'b1, '0, '0, hs);
        mem[31] = DW'($urandom);
        for (int i = 0; i < 400; i++) begin
            v = N'($urandom_range(0, 3));
            for (int r = 0; r < N; r++)
                a[r*AW +: AW] = ($urandom % 2 == 0) ? 5'd31 : AW'($urandom_range(0, 31));
            step(1'b0, v, a, hs);
            n_cmp++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", mc, obs, m_exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = DW'(i * 7 + 1);
        reset_vec = {2'b00, 2'b00, 8'h00, 5'd31, 1'b0};
        test_reset();
        test_allowed();
        test_denied();
        test_alternate();
        test_lockout();
        test_reset_mid();
        test_mixed();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
